// File: rtl/stream_pkg.sv
// Shared constants and width helpers for the stream multiplexer slice.
package stream_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Channel index width, never narrower than one bit (N=1 still has an index port).
    function automatic int cw_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way request arbiter: round-robin from a rotating pointer, or fixed lowest-index priority.
module rr_arbiter
    import stream_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MODE_RR,
    parameter int CW   = cw_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] idx
);

    logic [CW-1:0] ptr;
    logic [CW-1:0] ptr_nxt;
    logic [N-1:0]  rot;
    logic          found;
    int            cand;

    // Scan N candidates starting at ptr (or 0 in fixed mode); first requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        rot   = '0;
        for (int k = 0; k < N; k++) begin
            cand = (MODE == MODE_FIXED) ? k : (int'(ptr) + k) % N;
            rot  = req >> cand;
            if (en && !found && rot[0]) begin
                found = 1'b1;
                grant = N'(1) << cand;
                idx   = CW'(cand);
            end
        end
    end

    assign ptr_nxt = CW'((int'(idx) + 1) % N);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (MODE == MODE_RR && found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with internal arbitration and a one-word output register.
module stream_mux_rr
    import stream_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = MODE_RR,
    parameter int CW   = cw_of(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_chan,
    input  logic           out_ready
);

    logic          load;
    logic          arb_en;
    logic [N-1:0]  grant;
    logic [CW-1:0] gidx;
    logic [W-1:0]  sel_data;

    logic          vld_p1;
    logic [W-1:0]  data_p1;
    logic [CW-1:0] chan_p1;

    // The register may refill in the same cycle it drains, so throughput is one word per cycle.
    assign load   = !vld_p1 || out_ready;
    assign arb_en = load && !rst;

    rr_arbiter #(
        .N   (N),
        .MODE(MODE),
        .CW  (CW)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (in_valid),
        .en   (arb_en),
        .grant(grant),
        .idx  (gidx)
    );

    assign sel_data = W'(in_data >> (int'(gidx) * W));
    assign in_ready = grant;

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            chan_p1 <= '0;
        end else if (load) begin
            vld_p1 <= |grant;
            if (|grant) begin
                data_p1 <= sel_data;
                chan_p1 <= gidx;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_chan  = chan_p1;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: one round-robin instance and one fixed-priority instance.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  in_valid_a;
    logic [31:0] in_data_a;
    logic [3:0]  in_ready_a;
    logic        out_valid_a;
    logic [7:0]  out_data_a;
    logic [1:0]  out_chan_a;
    logic        out_ready_a;

    logic [3:0]  in_valid_b;
    logic [31:0] in_data_b;
    logic [3:0]  in_ready_b;
    logic        out_valid_b;
    logic [7:0]  out_data_b;
    logic [1:0]  out_chan_b;
    logic        out_ready_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.N(4), .W(8), .MODE(0)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_chan(out_chan_a),
        .out_ready(out_ready_a)
    );

    stream_mux_rr #(.N(4), .W(8), .MODE(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_chan(out_chan_b),
        .out_ready(out_ready_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid_a = 4'hF; in_data_a = 32'hA3A2A1A0; out_ready_a = 1'b1;
        in_valid_b = 4'hF; in_data_b = 32'hB3B2B1B0; out_ready_b = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d got %b exp 0", c, out_valid_a); end
            checks++; if (in_ready_a !== 4'b0000) begin errors++; $display("FAIL reset_in_ready cyc%0d got %b exp 0000", c, in_ready_a); end
            checks++; if (out_chan_a !== 2'd0) begin errors++; $display("FAIL reset_chan cyc%0d got %0d exp 0", c, out_chan_a); end
            checks++; if (out_data_a !== 8'h00) begin errors++; $display("FAIL reset_data cyc%0d got %h exp 00", c, out_data_a); end
            checks++; if (in_ready_b !== 4'b0000) begin errors++; $display("FAIL reset_in_ready_b cyc%0d got %b exp 0000", c, in_ready_b); end
        end
    endtask

    task automatic test_rr_fairness();
        logic [7:0] exp_d;
        logic [3:0] exp_r;
        rst = 1'b0;
        #1;
        checks++; if (in_ready_a !== 4'b0001) begin errors++; $display("FAIL rr_first_ready got %b exp 0001", in_ready_a); end
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_d = 8'hA0 + 8'(k % 4);
            exp_r = 4'b0001 << ((k + 1) % 4);
            checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL rr_valid k%0d got %b exp 1", k, out_valid_a); end
            checks++; if (out_chan_a !== 2'(k % 4)) begin errors++; $display("FAIL rr_chan k%0d got %0d exp %0d", k, out_chan_a, k % 4); end
            checks++; if (out_data_a !== exp_d) begin errors++; $display("FAIL rr_data k%0d got %h exp %h", k, out_data_a, exp_d); end
            checks++; if (in_ready_a !== exp_r) begin errors++; $display("FAIL rr_ready k%0d got %b exp %b", k, in_ready_a, exp_r); end
        end
    endtask

    task automatic test_back_pressure();
        // ptr is 1 after the fairness run; only channel 2 requests, carrying 55.
        in_valid_a = 4'b0100; in_data_a = 32'hA355A1A0;
        tick();
        checks++; if (out_data_a !== 8'h55 || out_chan_a !== 2'd2) begin errors++; $display("FAIL bp_setup got %h/%0d exp 55/2", out_data_a, out_chan_a); end
        out_ready_a = 1'b0; in_valid_a = 4'hF; in_data_a = 32'hA366A1A0;
        #1;
        checks++; if (in_ready_a !== 4'b0000) begin errors++; $display("FAIL bp_ready_now got %b exp 0000", in_ready_a); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d got %b exp 1", c, out_valid_a); end
            checks++; if (out_data_a !== 8'h55) begin errors++; $display("FAIL bp_data cyc%0d got %h exp 55", c, out_data_a); end
            checks++; if (out_chan_a !== 2'd2) begin errors++; $display("FAIL bp_chan cyc%0d got %0d exp 2", c, out_chan_a); end
            checks++; if (in_ready_a !== 4'b0000) begin errors++; $display("FAIL bp_ready cyc%0d got %b exp 0000", c, in_ready_a); end
        end
        out_ready_a = 1'b1;
        #1;
        checks++; if (in_ready_a !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b exp 1000", in_ready_a); end
        tick();
        checks++; if (out_data_a !== 8'hA3 || out_chan_a !== 2'd3) begin errors++; $display("FAIL bp_reload got %h/%0d exp a3/3", out_data_a, out_chan_a); end
    endtask

    task automatic test_sparse_wrap();
        in_data_a = 32'hA3A2A1A0;
        in_valid_a = 4'b1000;
        tick();
        checks++; if (out_chan_a !== 2'd3 || out_data_a !== 8'hA3) begin errors++; $display("FAIL sparse_ch3 got %0d/%h exp 3/a3", out_chan_a, out_data_a); end
        in_valid_a = 4'hF;
        tick();
        checks++; if (out_chan_a !== 2'd0 || out_data_a !== 8'hA0) begin errors++; $display("FAIL wrap_to_0 got %0d/%h exp 0/a0", out_chan_a, out_data_a); end
        in_valid_a = 4'b0001;
        #1;
        checks++; if (in_ready_a !== 4'b0001) begin errors++; $display("FAIL sparse_ch0_ready got %b exp 0001", in_ready_a); end
        tick();
        checks++; if (out_chan_a !== 2'd0 || out_valid_a !== 1'b1) begin errors++; $display("FAIL sparse_ch0 got %0d/%b exp 0/1", out_chan_a, out_valid_a); end
        in_valid_a = 4'b0000;
        tick();
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid_a); end
        checks++; if (in_ready_a !== 4'b0000) begin errors++; $display("FAIL idle_ready got %b exp 0000", in_ready_a); end
    endtask

    task automatic test_fixed_priority();
        in_valid_b = 4'b1010; out_ready_b = 1'b1;
        #1;
        checks++; if (in_ready_b !== 4'b0010) begin errors++; $display("FAIL fix_ready0 got %b exp 0010", in_ready_b); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (out_chan_b !== 2'd1 || out_data_b !== 8'hB1) begin errors++; $display("FAIL fix_ch1 cyc%0d got %0d/%h exp 1/b1", c, out_chan_b, out_data_b); end
            checks++; if (in_ready_b !== 4'b0010) begin errors++; $display("FAIL fix_starve cyc%0d got %b exp 0010", c, in_ready_b); end
        end
        in_valid_b = 4'b1000;
        tick();
        checks++; if (out_chan_b !== 2'd3 || out_data_b !== 8'hB3) begin errors++; $display("FAIL fix_ch3 got %0d/%h exp 3/b3", out_chan_b, out_data_b); end
    endtask

    task automatic test_reset_mid();
        in_valid_a = 4'b0100; out_ready_a = 1'b1;
        tick();
        checks++; if (out_chan_a !== 2'd2 || out_valid_a !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d/%b exp 2/1", out_chan_a, out_valid_a); end
        out_ready_a = 1'b0; rst = 1'b1;
        tick();
        checks++; if (out_valid_a !== 1'b0 || out_data_a !== 8'h00 || out_chan_a !== 2'd0) begin errors++; $display("FAIL mid_reset got %b/%h/%0d exp 0/00/0", out_valid_a, out_data_a, out_chan_a); end
        rst = 1'b0; in_valid_a = 4'hF; out_ready_a = 1'b1;
        #1;
        checks++; if (in_ready_a !== 4'b0001) begin errors++; $display("FAIL mid_ptr_ready got %b exp 0001", in_ready_a); end
        tick();
        checks++; if (out_chan_a !== 2'd0 || out_data_a !== 8'hA0) begin errors++; $display("FAIL mid_first got %0d/%h exp 0/a0", out_chan_a, out_data_a); end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_back_pressure();
        test_sparse_wrap();
        test_fixed_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
